branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//  EX-stage partner of the IF-stage branch predictor. Resolves each control-transfer
//  instruction: computes the actual direction and target, and compares them with the
//  prediction carried down the pipeline. Registers the old_* feedback bundle that the
//  predictor uses to update its BHT and raise predict_fail. Keeps saturating counters
//  of resolved branches and mispredictions for performance monitoring.
// PARAMETERS
//  CNT_WID   32   width of each performance counter
// PORTS
//  clk              in   1   system clock (the block's only clock)
//  rst              in   1   synchronous, active-high reset
//  stall            in   1   pipeline stall; all registered state holds
//  predict_fail     in   1   predictor flush, computed from this block's outputs; squashes the EX instruction
//  ex_valid         in   1   EX slot holds a real instruction
//  ex_branch        in   1   instruction is jal/jalr/Bxx
//  ex_cond          in   1   instruction is a conditional Bxx (the predictor's "predict" class)
//  ex_jalr          in   1   instruction is jalr (target = rs1+imm)
//  ex_funct3        in   3   branch compare type
//  ex_pc            in   32  PC of the EX instruction
//  ex_imm           in   32  sign-extended immediate
//  ex_rs1_data      in   32  forwarded rs1 value
//  ex_rs2_data      in   32  forwarded rs2 value
//  ex_predict       in   1   predict_result carried from IF
//  ex_predict_pc    in   32  target_pc the predictor chose for this instruction
//  old_pc           out  32  correct next PC of the resolved instruction
//  old_branch_pc    out  32  PC of the resolved instruction (BHT update index)
//  old_predict_pc   out  32  PC the predictor fetched next
//  old_predict      out  1   registered ex_predict
//  old_actual       out  1   actual direction (1 = taken)
//  old_branch       out  1   resolved instruction was a branch/jump
//  perf_branches    out  CNT_WID  resolved branch count
//  perf_mispredicts out  CNT_WID  mispredicted branch count
// BEHAVIOUR
//  - Reset: every output is 0; both counters are 0. rst has priority over every other input.
//  - Latency: resolution is combinational in EX. Outputs are registered and appear
//    1 cycle after capture. The predictor sees predict_fail in that following cycle.
//  - Per-cycle update priority: rst > stall (all registers hold) > squash > capture.
//  - Squash: if predict_fail=1 and stall=0, the EX instruction is wrong-path.
//    old_branch, old_actual and old_predict load 0. old_pc loads ex_pc+4 and
//    old_predict_pc loads ex_pc+4 (no second flush). Counters hold.
//  - Capture (ex_valid=1, ex_branch=1):
//      taken = !ex_cond | cmp, where cmp by funct3 is:
//        000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge;
//        010/011 give cmp=0.
//      tgt = ex_jalr ? ((rs1+imm) & ~32'h1) : ex_pc+ex_imm.
//      All arithmetic is 32-bit, wrapping with no overflow flag.
//      old_pc = taken ? tgt : ex_pc+4; old_actual = taken; old_branch = 1;
//      old_branch_pc = ex_pc; old_predict = ex_predict; old_predict_pc = ex_predict_pc.
//  - Capture of a non-branch, or ex_valid=0: old_branch/old_actual/old_predict = 0.
//    old_pc = old_predict_pc = ex_pc+4, old_branch_pc = ex_pc.
//  - mispred = (taken != ex_predict) | (old_pc_next != ex_predict_pc).
//    It is evaluated only on a branch capture.
//  - Counters: on a branch capture perf_branches += 1, and perf_mispredicts += mispred.
//    Both saturate at all-ones (no wrap). They hold under stall, squash and reset-free idle.
//  - Invariant: outputs never cause predict_fail for non-branch or squashed slots.
// TESTING
//  1. beq, rs1=rs2=5, pc=0x100, imm=0x20, predict=1, ppc=0x120
//     -> next cycle old_pc=0x120, actual=1, branch=1; no fail; branches=1, mispredicts=0.
//  2. blt, rs1=-1, rs2=0 (signed), predict=0, ppc=0x104, pc=0x100, imm=8
//     -> old_actual=1, old_pc=0x108; mispredicts+1.
//     Repeat with bltu: actual=0, old_pc=0x104.
//  3. jalr, rs1=0x2003, imm=0, predict=1, ppc=0x2000
//     -> old_pc=0x2002; target mismatch, so mispredicts+1.
//     With ppc=0x2002: no mispredict.
//  4. Hold predict_fail=1 with a valid beq in EX
//     -> old_branch=0, old_pc=old_predict_pc=ex_pc+4; counters unchanged.
//  5. stall=1 for 3 cycles while EX inputs change -> all outputs and counters frozen;
//     the capture happens on the first cycle after stall drops.
//  6. Preload counters to all-ones via forced branches, then one more mispredicted branch
//     -> both stay 0xFFFFFFFF.
//     Assert rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - EX-stage branch resolution, predictor feedback registers and perf counters
module branch_resolver #(
    parameter int CNT_WID = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               predict_fail,
    input  logic               ex_valid,
    input  logic               ex_branch,
    input  logic               ex_cond,
    input  logic               ex_jalr,
    input  logic [2:0]         ex_funct3,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_imm,
    input  logic [31:0]        ex_rs1_data,
    input  logic [31:0]        ex_rs2_data,
    input  logic               ex_predict,
    input  logic [31:0]        ex_predict_pc,
    output logic [31:0]        old_pc,
    output logic [31:0]        old_branch_pc,
    output logic [31:0]        old_predict_pc,
    output logic               old_predict,
    output logic               old_actual,
    output logic               old_branch,
    output logic [CNT_WID-1:0] perf_branches,
    output logic [CNT_WID-1:0] perf_mispredicts
);

    logic        cmp;
    logic        taken;
    logic        is_branch;
    logic        mispred;
    logic [31:0] pc_plus4;
    logic [31:0] tgt;
    logic [31:0] pc_next;

    always_comb begin
        cmp = 1'b0;
        case (ex_funct3)
            3'b000:  cmp = (ex_rs1_data == ex_rs2_data);
            3'b001:  cmp = (ex_rs1_data != ex_rs2_data);
            3'b100:  cmp = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
            3'b101:  cmp = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
            3'b110:  cmp = (ex_rs1_data <  ex_rs2_data);
            3'b111:  cmp = (ex_rs1_data >= ex_rs2_data);
            default: cmp = 1'b0;
        endcase
    end

    // Unconditional jumps are always taken; jalr clears bit 0 of its target.
    assign taken     = !ex_cond | cmp;
    assign pc_plus4  = ex_pc + 32'd4;
    assign tgt       = ex_jalr ? ((ex_rs1_data + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    assign pc_next   = taken ? tgt : pc_plus4;
    assign is_branch = ex_valid & ex_branch;
    assign mispred   = (taken != ex_predict) | (pc_next != ex_predict_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            old_pc           <= '0;
            old_branch_pc    <= '0;
            old_predict_pc   <= '0;
            old_predict      <= 1'b0;
            old_actual       <= 1'b0;
            old_branch       <= 1'b0;
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (!stall) begin
            if (predict_fail) begin
                // Wrong-path slot: report a fall-through that cannot trigger another flush.
                old_pc         <= pc_plus4;
                old_branch_pc  <= ex_pc;
                old_predict_pc <= pc_plus4;
                old_predict    <= 1'b0;
                old_actual     <= 1'b0;
                old_branch     <= 1'b0;
            end else if (is_branch) begin
                old_pc         <= pc_next;
                old_branch_pc  <= ex_pc;
                old_predict_pc <= ex_predict_pc;
                old_predict    <= ex_predict;
                old_actual     <= taken;
                old_branch     <= 1'b1;
                if (perf_branches != '1)
                    perf_branches <= perf_branches + CNT_WID'(1);
                if (mispred && (perf_mispredicts != '1))
                    perf_mispredicts <= perf_mispredicts + CNT_WID'(1);
            end else begin
                old_pc         <= pc_plus4;
                old_branch_pc  <= ex_pc;
                old_predict_pc <= pc_plus4;
                old_predict    <= 1'b0;
                old_actual     <= 1'b0;
                old_branch     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, stall, predict_fail;
    logic          ex_valid, ex_branch, ex_cond, ex_jalr;
    logic [2:0]    ex_funct3;
    logic [31:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic          ex_predict;
    logic [31:0]   ex_predict_pc;
    logic [31:0]   old_pc, old_branch_pc, old_predict_pc;
    logic          old_predict, old_actual, old_branch;
    logic [CW-1:0] perf_branches, perf_mispredicts;

    int n_chk  = 0;
    int n_fail = 0;

    branch_resolver #(.CNT_WID(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .predict_fail(predict_fail),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_cond(ex_cond), .ex_jalr(ex_jalr),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_predict(ex_predict), .ex_predict_pc(ex_predict_pc),
        .old_pc(old_pc), .old_branch_pc(old_branch_pc), .old_predict_pc(old_predict_pc),
        .old_predict(old_predict), .old_actual(old_actual), .old_branch(old_branch),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic br, input logic cond, input logic jalr,
                          input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic pred, input logic [31:0] ppc);
        ex_valid = v; ex_branch = br; ex_cond = cond; ex_jalr = jalr; ex_funct3 = f3;
        ex_pc = pc; ex_imm = imm; ex_rs1_data = rs1; ex_rs2_data = rs2;
        ex_predict = pred; ex_predict_pc = ppc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int br, input int mp);
        chk({tag, ".branches"}, 32'(perf_branches), br);
        chk({tag, ".mispredicts"}, 32'(perf_mispredicts), mp);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; predict_fail = 1'b0;
        set_ex(1, 1, 1, 0, 3'b000, 32'h100, 32'h20, 5, 5, 1, 32'h120);
        tick; tick;
        chk("rst.old_pc", old_pc, 0);
        chk("rst.old_branch_pc", old_branch_pc, 0);
        chk("rst.old_predict_pc", old_predict_pc, 0);
        chk("rst.flags", {old_predict, old_actual, old_branch}, 0);
        chk_cnt("rst", 0, 0);
        rst = 1'b0;

        // beq taken, correctly predicted
        tick;
        chk("beq.old_pc", old_pc, 32'h120);
        chk("beq.actual", old_actual, 1);
        chk("beq.branch", old_branch, 1);
        chk("beq.branch_pc", old_branch_pc, 32'h100);
        chk_cnt("beq", 1, 0);

        // blt signed: -1 < 0 taken, predicted not taken
        set_ex(1, 1, 1, 0, 3'b100, 32'h100, 32'h8, 32'hFFFF_FFFF, 0, 0, 32'h104);
        tick;
        chk("blt.actual", old_actual, 1);
        chk("blt.old_pc", old_pc, 32'h108);
        chk_cnt("blt", 2, 1);

        // bltu: 0xFFFFFFFF < 0 false
        set_ex(1, 1, 1, 0, 3'b110, 32'h100, 32'h8, 32'hFFFF_FFFF, 0, 0, 32'h104);
        tick;
        chk("bltu.actual", old_actual, 0);
        chk("bltu.old_pc", old_pc, 32'h104);
        chk_cnt("bltu", 3, 1);

        // jalr with odd base, wrong predicted target
        set_ex(1, 1, 0, 1, 3'b000, 32'h300, 0, 32'h2003, 0, 1, 32'h2000);
        tick;
        chk("jalr.old_pc", old_pc, 32'h2002);
        chk("jalr.actual", old_actual, 1);
        chk("jalr.predict_pc", old_predict_pc, 32'h2000);
        chk_cnt("jalr_miss", 4, 2);

        set_ex(1, 1, 0, 1, 3'b000, 32'h300, 0, 32'h2003, 0, 1, 32'h2002);
        tick;
        chk("jalr_hit.old_pc", old_pc, 32'h2002);
        chk_cnt("jalr_hit", 5, 2);

        // funct3 010 never taken
        set_ex(1, 1, 1, 0, 3'b010, 32'h380, 32'h40, 7, 7, 0, 32'h384);
        tick;
        chk("f3_010.actual", old_actual, 0);
        chk("f3_010.old_pc", old_pc, 32'h384);
        chk_cnt("f3_010", 6, 2);

        // bge signed 0 >= -1, backward target
        set_ex(1, 1, 1, 0, 3'b101, 32'h390, 32'hFFFF_FFF0, 0, 32'hFFFF_FFFF, 1, 32'h380);
        tick;
        chk("bge.actual", old_actual, 1);
        chk("bge.old_pc", old_pc, 32'h380);
        chk_cnt("bge", 7, 2);

        // squash a valid taken beq
        predict_fail = 1'b1;
        set_ex(1, 1, 1, 0, 3'b000, 32'h400, 32'h40, 3, 3, 1, 32'h440);
        tick;
        predict_fail = 1'b0;
        chk("squash.branch", old_branch, 0);
        chk("squash.actual", old_actual, 0);
        chk("squash.predict", old_predict, 0);
        chk("squash.old_pc", old_pc, 32'h404);
        chk("squash.predict_pc", old_predict_pc, 32'h404);
        chk_cnt("squash", 7, 2);

        // non-branch capture, then stall while EX changes
        set_ex(1, 0, 0, 0, 3'b000, 32'h500, 32'h10, 1, 2, 1, 32'h999);
        tick;
        chk("nonbr.old_pc", old_pc, 32'h504);
        chk("nonbr.predict_pc", old_predict_pc, 32'h504);
        chk("nonbr.flags", {old_predict, old_actual, old_branch}, 0);
        chk_cnt("nonbr", 7, 2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 1, 1, 0, 3'b000, 32'h600 + 32'(i), 32'h10, 9, 9, 0, 32'h604);
            tick;
            chk("stall.old_pc", old_pc, 32'h504);
            chk("stall.branch", old_branch, 0);
            chk_cnt("stall", 7, 2);
        end
        stall = 1'b0;
        set_ex(1, 1, 1, 0, 3'b000, 32'h600, 32'h10, 9, 9, 1, 32'h610);
        tick;
        chk("unstall.old_pc", old_pc, 32'h610);
        chk("unstall.branch", old_branch, 1);
        chk_cnt("unstall", 8, 2);

        // invalid slot is not a branch capture
        set_ex(0, 1, 1, 0, 3'b000, 32'h700, 32'h40, 1, 1, 1, 32'h740);
        tick;
        chk("invalid.branch", old_branch, 0);
        chk("invalid.old_pc", old_pc, 32'h704);
        chk_cnt("invalid", 8, 2);

        // drive counters into saturation with mispredicted branches
        set_ex(1, 1, 1, 0, 3'b000, 32'h800, 32'h20, 4, 4, 0, 32'h804);
        for (int i = 0; i < 13; i++) tick;
        chk_cnt("sat", 15, 15);
        tick;
        chk_cnt("sat_more", 15, 15);
        chk("sat.old_pc", old_pc, 32'h820);

        rst = 1'b1;
        tick;
        chk("rst2.old_pc", old_pc, 0);
        chk("rst2.old_branch_pc", old_branch_pc, 0);
        chk("rst2.old_predict_pc", old_predict_pc, 0);
        chk("rst2.flags", {old_predict, old_actual, old_branch}, 0);
        chk_cnt("rst2", 0, 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
